// File: rtl/pc_pkg.sv
// pc_pkg: FSM state encoding and default reset vector shared by the PC fetch unit.
package pc_pkg;
    localparam int STATE_W = 2;
    typedef enum logic [STATE_W-1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;
    localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0000_0000;
endpackage

// File: rtl/pc_incr.sv
// pc_incr: sequential-step adder for the PC, wrapping modulo 2^XLEN.
module pc_incr #(
    parameter int XLEN = 32,
    parameter int INCR = 4
) (
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] sum
);
    assign sum = pc + XLEN'(INCR);
endmodule

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: registered PC with fetch handshake, redirect/trap/halt control and link address.
// Define PC_ALIGN_CHECK_EN to reject misaligned redirects instead of masking their low bits.
module pc_fetch_ctrl
    import pc_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_VEC  = XLEN'(DEFAULT_RESET_VEC),
    parameter int              INCR       = 4,
    parameter int              ALIGN_BITS = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_target,
    input  logic               trap_valid,
    input  logic [XLEN-1:0]    trap_vec,
    input  logic               halt_req,
    input  logic               resume,
    input  logic               fetch_ready,
    output logic               fetch_valid,
    output logic [XLEN-1:0]    fetch_pc,
    output logic [XLEN-1:0]    pc_plus_incr,
    output logic [STATE_W-1:0] state_o,
    output logic               misalign_err
);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~((XLEN'(1) << ALIGN_BITS) - XLEN'(1));

    state_t          state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] redir_tgt;
    logic [XLEN-1:0] trap_tgt;
    logic            redir_bad;
    logic            redir_take;

    pc_incr #(.XLEN(XLEN), .INCR(INCR)) u_incr (.pc(pc), .sum(pc_plus_incr));

`ifdef PC_ALIGN_CHECK_EN
    assign redir_bad = redirect_valid && |(redirect_target & ~ALIGN_MASK);
    assign redir_tgt = redirect_target;
    assign trap_tgt  = trap_vec;
`else
    assign redir_bad = 1'b0;
    assign redir_tgt = redirect_target & ALIGN_MASK;
    assign trap_tgt  = trap_vec & ALIGN_MASK;
`endif

    assign redir_take = redirect_valid && !redir_bad;
    assign fetch_pc   = pc;
    assign state_o    = state;

    // A rejected redirect only reports an error when it would otherwise have won priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_BOOT;
            pc           <= RESET_VEC;
            fetch_valid  <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= redir_bad && !trap_valid && state != ST_BOOT;
            case (state)
                ST_BOOT: begin
                    state       <= ST_RUN;
                    fetch_valid <= 1'b1;
                end
                ST_RUN: begin
                    pc <= trap_valid ? trap_tgt :
                          redir_take ? redir_tgt :
                          (fetch_valid && fetch_ready) ? pc_plus_incr : pc;
                    if (halt_req) begin
                        state       <= ST_HALT;
                        fetch_valid <= 1'b0;
                    end
                end
                ST_HALT: begin
                    pc <= trap_valid ? trap_tgt : redir_take ? redir_tgt : pc;
                    if (trap_valid || resume) begin
                        state       <= ST_RUN;
                        fetch_valid <= 1'b1;
                    end
                end
                default: begin
                    state       <= ST_BOOT;
                    fetch_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule
